// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder controller.
//   state_t      : FSM encoding (IDLE=0, RUN=1, DONE=2)
//   WIDTH_MAX    : largest supported operand width
//   CNT_W_MAX    : bit counter width that covers WIDTH_MAX-1
//   cnt_width()  : bit counter width that holds WIDTH-1 for a given WIDTH
// -----------------------------------------------------------------------------
package serial_add_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;
   localparam int CNT_W_MAX = $clog2(WIDTH_MAX);

   // $clog2(w) bits are enough to count 0..w-1; never return fewer than 1 bit.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Single-bit full adder cell shared by the serial adder controller.
// Ports:
//   A, B  : operand bits
//   C_i   : carry in
//   S_o   : sum bit
//   C_o   : carry out
// -----------------------------------------------------------------------------
module full_adder (
   input  logic A,
   input  logic B,
   input  logic C_i,
   output logic C_o,
   output logic S_o
);

   logic w_axb;

   assign w_axb = A ^ B;
   assign S_o   = w_axb ^ C_i;
   assign C_o   = (A & B) | (C_i & w_axb);

endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder: one shared full_adder processes one bit pair per clock,
// LSB first, with the carry held in a register between cycles. The finished
// sum and carry-out are copied to output registers on the last RUN edge and a
// one-cycle DONE_o pulse follows.
//
// Optional feature macro: SERIAL_ADD_SUB_EN
//   When defined, SUB_i exists; SUB_i=1 on an accepted start captures ~B_i and
//   forces the initial carry to 1, giving A - B (C_o=1 means no borrow).
//
// Ports:
//   CLK_i    : clock, rising edge
//   RSTn_i   : asynchronous active-low reset
//   START_i  : start request, sampled only in IDLE
//   A_i, B_i : operands, captured on accepted start
//   C_i      : carry-in, captured on accepted start
//   SUB_i    : subtract select (SERIAL_ADD_SUB_EN only)
//   BUSY_o   : high during RUN and DONE
//   DONE_o   : one-cycle completion pulse
//   S_o      : registered sum
//   C_o      : registered carry-out
// -----------------------------------------------------------------------------
import serial_add_pkg::*;

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             CLK_i,
   input  logic             RSTn_i,
   input  logic             START_i,
   input  logic [WIDTH-1:0] A_i,
   input  logic [WIDTH-1:0] B_i,
   input  logic             C_i,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             SUB_i,
`endif
   output logic             BUSY_o,
   output logic             DONE_o,
   output logic [WIDTH-1:0] S_o,
   output logic             C_o
);

   localparam int                CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             r_state;
   state_t             w_next;
   logic               w_accept;
   logic               w_run_last;

   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic [WIDTH-1:0]   r_sum_sh;
   logic               r_carry;
   logic [CNT_W-1:0]   r_cnt;

   logic [WIDTH-1:0]   r_s;
   logic               r_c;
   logic               r_busy;
   logic               r_done;

   logic               w_fa_s;
   logic               w_fa_c;
   logic [WIDTH-1:0]   w_sum_next;
   logic [WIDTH-1:0]   w_b_load;
   logic               w_c_load;

   // Operand conditioning at capture time: subtraction is A + ~B + 1.
`ifdef SERIAL_ADD_SUB_EN
   assign w_b_load = SUB_i ? ~B_i : B_i;
   assign w_c_load = SUB_i ? 1'b1 : C_i;
`else
   assign w_b_load = B_i;
   assign w_c_load = C_i;
`endif

   full_adder u_fa (
      .A   (r_a_sh[0]),
      .B   (r_b_sh[0]),
      .C_i (r_carry),
      .C_o (w_fa_c),
      .S_o (w_fa_s)
   );

   // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at [0].
   assign w_sum_next = {w_fa_s, r_sum_sh[WIDTH-1:1]};

   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_run_last = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (START_i) begin
               w_next   = ST_RUN;
               w_accept = 1'b1;
            end
         end
         ST_RUN: begin
            if (r_cnt == LAST_CNT) begin
               w_next     = ST_DONE;
               w_run_last = 1'b1;
            end
         end
         ST_DONE: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_i or negedge RSTn_i) begin
      if (!RSTn_i) begin
         r_state  <= ST_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_sum_sh <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_s      <= '0;
         r_c      <= 1'b0;
      end else begin
         r_state <= w_next;
         // Status flags are registered from the next state so they line up
         // exactly with the state they describe.
         r_busy  <= (w_next != ST_IDLE);
         r_done  <= (w_next == ST_DONE);

         if (w_accept) begin
            r_a_sh   <= A_i;
            r_b_sh   <= w_b_load;
            r_carry  <= w_c_load;
            r_sum_sh <= '0;
            r_cnt    <= '0;
         end else if (r_state == ST_RUN) begin
            r_sum_sh <= w_sum_next;
            r_carry  <= w_fa_c;
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_cnt    <= r_cnt + 1'b1;
            // Outputs take the complete word directly, so partial sums are
            // never exposed.
            if (w_run_last) begin
               r_s <= w_sum_next;
               r_c <= w_fa_c;
            end
         end
      end
   end

   assign BUSY_o = r_busy;
   assign DONE_o = r_done;
   assign S_o    = r_s;
   assign C_o    = r_c;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Self-checking bench for serial_add_ctrl (WIDTH=8). A reference sum is pushed
// to a scoreboard when an operation is accepted; a monitor pops and compares
// on every DONE_o pulse, including the acceptance-to-DONE latency.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      int           acc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] s;
   logic         cout;

   int   n_chk  = 0;
   int   n_fail = 0;
   int   n_done = 0;
   int   cyc    = 0;
   exp_t sb[$];

   serial_add_ctrl #(.WIDTH(W)) dut (
      .CLK_i   (clk),
      .RSTn_i  (rstn),
      .START_i (start),
      .A_i     (a),
      .B_i     (b),
      .C_i     (cin),
`ifdef SERIAL_ADD_SUB_EN
      .SUB_i   (sub),
`endif
      .BUSY_o  (busy),
      .DONE_o  (done),
      .S_o     (s),
      .C_o     (cout)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                  input logic ci, input logic sb_i, input int acc);
      exp_t        e;
      logic [W:0]  r;
      if (sb_i) r = {1'b0, ai} + {1'b0, ~bi} + (W+1)'(1);
      else      r = {1'b0, ai} + {1'b0, bi} + (W+1)'(ci);
      e.s   = r[W-1:0];
      e.c   = r[W];
      e.acc = acc;
      return e;
   endfunction

   // Scoreboard monitor
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (rstn && done) begin
         n_done++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sum", 32'(s), 32'(e.s));
            chk("cout", 32'(cout), 32'(e.c));
            chk("latency", 32'(cyc - e.acc), 32'(W));
         end
      end
   end

   task automatic wait_idle();
      int k;
      for (k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!busy && !done) break;
      end
      if (k == 40) chk("timeout_idle", 32'd1, 32'd0);
   endtask

   // Issue one start from IDLE and wait for the operation to finish.
   task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic ci, input logic sb_i);
      @(negedge clk);
      a = ai; b = bi; cin = ci; sub = sb_i; start = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back(model(ai, bi, ci, sb_i, cyc));
      chk("busy_after_accept", 32'(busy), 32'd1);
      @(negedge clk);
      start = 1'b0;
      wait_idle();
   endtask

   initial begin
      int t0;
      int dones;
      int lowcnt;
      int nd0;
      logic [W-1:0] s_prev;
      logic         c_prev;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_c", 32'(cout), 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Basic additions and carry boundaries
      do_op(8'h35, 8'h4A, 1'b0, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0, 1'b0);
      do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
      do_op(8'h00, 8'h00, 1'b1, 1'b0);

      // START pulsed every cycle with changing operands during RUN
      s_prev = s;
      c_prev = cout;
      @(negedge clk);
      a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      sb.push_back(model(8'h12, 8'h34, 1'b0, 1'b0, cyc));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            start = 1'b0;
            break;
         end
         chk("hold_s", 32'(s), 32'(s_prev));
         chk("hold_c", 32'(cout), 32'(c_prev));
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      start = 1'b0;
      wait_idle();

      // Reset mid-RUN after 3 bits
      @(negedge clk);
      a = 8'hC3; b = 8'h3C; cin = 1'b1; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_s", 32'(s), 32'd0);
      chk("midrst_c", 32'(cout), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      nd0 = n_done;
      repeat (12) @(negedge clk);
      chk("no_done_after_rst", 32'(n_done - nd0), 32'd0);
      do_op(8'h80, 8'h80, 1'b0, 1'b0);
      do_op(8'h5A, 8'h0F, 1'b1, 1'b0);

      // START held high: three back-to-back operations
      @(negedge clk);
      a = 8'hA5; b = 8'h5A; cin = 1'b1; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      for (int k = 0; k < 3; k++)
         sb.push_back(model(8'hA5, 8'h5A, 1'b1, 1'b0, t0 + k * (W + 2)));
      dones  = 0;
      lowcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) lowcnt++;
         if (done) begin
            dones++;
            if (dones == 3) begin
               start = 1'b0;
               break;
            end
         end
      end
      start = 1'b0;
      chk("held_dones", 32'(dones), 32'd3);
      chk("held_busy_low", 32'(lowcnt), 32'd2);
      wait_idle();

`ifdef SERIAL_ADD_SUB_EN
      do_op(8'h10, 8'h01, 1'b0, 1'b1);
      do_op(8'h00, 8'h01, 1'b1, 1'b1);
      do_op(8'h35, 8'h4A, 1'b0, 1'b0);
`endif

      repeat (4) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
